// File: rtl/div_stall_unit_if.sv
// Execute-stage divider bundle: operands/control from the pipeline, stall request and
// HI/LO results back. The divider is the initiator (master) of the stall request.
interface div_stall_unit_if #(
    parameter int WIDTH = 32
) ();
    logic             startE;
    logic             signedE;
    logic [WIDTH-1:0] srcaE;
    logic [WIDTH-1:0] srcbE;
    logic             cancel;
    logic             stall_div;
    logic             busy;
    logic             hilo_we;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;

    modport master (
        input  startE,
        input  signedE,
        input  srcaE,
        input  srcbE,
        input  cancel,
        output stall_div,
        output busy,
        output hilo_we,
        output hi_o,
        output lo_o
    );

    modport slave (
        output startE,
        output signedE,
        output srcaE,
        output srcbE,
        output cancel,
        input  stall_div,
        input  busy,
        input  hilo_we,
        input  hi_o,
        input  lo_o
    );
endinterface

// File: rtl/div_stall_unit.sv
// Iterative restoring divider for MIPS DIV/DIVU with pipeline stall request and HI/LO strobe.
// Optional macro DIV_ZERO_EARLY_EN: divide-by-zero skips the iteration and completes next cycle.
module div_stall_unit #(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              resetn,
    div_stall_unit_if.master  div_if
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_qsign;
    logic             r_rsign;

    logic             w_start;
    logic             w_early;
    logic             w_sa;
    logic             w_sb;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH-1:0] w_sub;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_n;
    logic [WIDTH-1:0] w_quo_n;

    assign w_start = div_if.startE & ~div_if.cancel;

`ifdef DIV_ZERO_EARLY_EN
    assign w_early = (div_if.srcbE == '0);
`else
    assign w_early = 1'b0;
`endif

    assign w_sa    = div_if.signedE & div_if.srcaE[WIDTH-1];
    assign w_sb    = div_if.signedE & div_if.srcbE[WIDTH-1];
    assign w_abs_a = w_sa ? (~div_if.srcaE + 1'b1) : div_if.srcaE;
    assign w_abs_b = w_sb ? (~div_if.srcbE + 1'b1) : div_if.srcbE;

    // Remainder stays below the divisor, so a no-borrow difference always fits WIDTH bits.
    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_ge    = (w_shift >= {1'b0, r_dvs});
    assign w_sub   = w_shift[WIDTH-1:0] - r_dvs;
    assign w_rem_n = w_ge ? w_sub : w_shift[WIDTH-1:0];
    assign w_quo_n = {r_quo[WIDTH-2:0], w_ge};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_dvs   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_qsign <= 1'b0;
            r_rsign <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        if (w_early) begin
                            r_lo    <= '1;
                            r_hi    <= div_if.srcaE;
                            r_state <= DONE;
                        end else begin
                            r_quo   <= w_abs_a;
                            r_dvs   <= w_abs_b;
                            r_rem   <= '0;
                            r_qsign <= w_sa ^ w_sb;
                            r_rsign <= w_sa;
                            r_cnt   <= CW'(WIDTH);
                            r_state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (div_if.cancel) begin
                        r_cnt   <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_rem <= w_rem_n;
                        r_quo <= w_quo_n;
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == CW'(1)) begin
                            r_lo    <= r_qsign ? (~w_quo_n + 1'b1) : w_quo_n;
                            r_hi    <= r_rsign ? (~w_rem_n + 1'b1) : w_rem_n;
                            r_state <= DONE;
                        end
                    end
                end
                DONE: begin
                    // startE is deliberately ignored so the completing instruction cannot restart.
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign div_if.stall_div = (r_state == BUSY) | ((r_state == IDLE) & w_start);
    assign div_if.busy      = (r_state == BUSY);
    assign div_if.hilo_we   = (r_state == DONE) & ~div_if.cancel;
    assign div_if.hi_o      = r_hi;
    assign div_if.lo_o      = r_lo;
endmodule

// File: tb/tb_div_stall_unit.sv
// Self-checking bench for div_stall_unit: directed table, hand sequences, random vs arithmetic model.
module tb_div_stall_unit;
    localparam int W = 32;

`ifdef DIV_ZERO_EARLY_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clk = 1'b0;
    logic resetn = 1'b1;
    always #5 clk = ~clk;

    div_stall_unit_if #(.WIDTH(W)) dif ();

    div_stall_unit #(.WIDTH(W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .div_if (dif)
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sg;
        logic [31:0] lo;
        logic [31:0] hi;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
        end
    endtask

    // Reference: plain integer division on magnitudes, then MIPS sign rules.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic sg,
                                  output logic [31:0] lo, output logic [31:0] hi);
        logic na, nb;
        logic [31:0] ua, ub, q, r;
        na = sg & a[31];
        nb = sg & b[31];
        ua = na ? 32'(0 - a) : a;
        ub = nb ? 32'(0 - b) : b;
        if (b == 32'd0) begin
            if (EARLY) begin
                lo = 32'hFFFF_FFFF;
                hi = a;
                return;
            end
            q = 32'hFFFF_FFFF;
            r = ua;
        end else begin
            q = ua / ub;
            r = ua % ub;
        end
        lo = (na ^ nb) ? 32'(0 - q) : q;
        hi = na ? 32'(0 - r) : r;
    endfunction

    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sg,
                           input int cancel_k, output int stall_cnt, output int we_cnt,
                           output int we_cyc, output logic [31:0] lo, output logic [31:0] hi);
        @(negedge clk);
        dif.startE  = 1'b1;
        dif.signedE = sg;
        dif.srcaE   = a;
        dif.srcbE   = b;
        dif.cancel  = 1'b0;
        #1;
        stall_cnt = dif.stall_div ? 1 : 0;
        we_cnt = 0;
        we_cyc = -1;
        lo = '0;
        hi = '0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            dif.startE  = 1'b0;
            dif.srcaE   = $urandom;
            dif.srcbE   = $urandom;
            dif.signedE = 1'($urandom);
            dif.cancel  = (k == cancel_k);
            #1;
            if (dif.stall_div) stall_cnt++;
            if (dif.hilo_we) begin
                we_cnt++;
                if (we_cyc < 0) begin
                    we_cyc = k;
                    lo = dif.lo_o;
                    hi = dif.hi_o;
                end
            end
        end
        dif.cancel = 1'b0;
    endtask

    task automatic check_div(input string nm, input logic [31:0] a, input logic [31:0] b,
                             input logic sg, input logic [31:0] elo, input logic [31:0] ehi);
        int sc, wc, wy, lat;
        logic [31:0] lo, hi;
        lat = (EARLY && b == 32'd0) ? 1 : W + 1;
        run_div(a, b, sg, 0, sc, wc, wy, lo, hi);
        chk({nm, "_stall_cycles"}, sc, lat);
        chk({nm, "_we_cycle"}, wy, lat);
        chk({nm, "_we_count"}, wc, 1);
        chk({nm, "_lo"}, lo, elo);
        chk({nm, "_hi"}, hi, ehi);
    endtask

    initial begin
        int sc, wc, wy, we1, we2, nwe;
        logic [31:0] lo, hi, elo, ehi, ra, rb;
        logic rs;

        vecs[0] = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2};
        vecs[1] = '{32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF};
        vecs[2] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0};
        vecs[3] = '{32'd9,          32'd3,          1'b0, 32'd3,          32'd0};
        vecs[4] = '{32'd10,         32'd4,          1'b0, 32'd2,          32'd2};
        vecs[5] = '{32'd5,          32'd0,          1'b0, 32'hFFFF_FFFF,  32'd5};
        vecs[6] = '{32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1};
        vecs[7] = '{32'hFFFF_FFF9,  32'hFFFF_FFFE,  1'b1, 32'd3,          32'hFFFF_FFFF};
        vecs[8] = '{32'hFFFF_FFF9,  32'd2,          1'b0, 32'h7FFF_FFFC,  32'd1};
        vecs[9] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'd0,          32'h8000_0000};

        dif.startE  = 1'b0;
        dif.signedE = 1'b0;
        dif.srcaE   = '0;
        dif.srcbE   = '0;
        dif.cancel  = 1'b0;
        #1 resetn = 1'b0;
        #2;
        chk("rst_stall", dif.stall_div, 0);
        chk("rst_busy", dif.busy, 0);
        chk("rst_we", dif.hilo_we, 0);
        chk("rst_hi", dif.hi_o, 0);
        chk("rst_lo", dif.lo_o, 0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < 10; i++) begin
            check_div($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sg,
                      vecs[i].lo, vecs[i].hi);
        end

        // Cancel mid-BUSY: no strobe, results untouched.
        run_div(32'd100, 32'd7, 1'b0, 10, sc, wc, wy, lo, hi);
        chk("cancel_busy_stall_cycles", sc, 11);
        chk("cancel_busy_we_count", wc, 0);
        chk("cancel_busy_hi_kept", dif.hi_o, vecs[9].hi);
        chk("cancel_busy_lo_kept", dif.lo_o, vecs[9].lo);

        // Cancel in DONE suppresses the strobe.
        run_div(32'd100, 32'd7, 1'b0, W + 1, sc, wc, wy, lo, hi);
        chk("cancel_done_stall_cycles", sc, W + 1);
        chk("cancel_done_we_count", wc, 0);

        // Back-to-back: start held through DONE must only take effect in the following IDLE.
        @(negedge clk);
        dif.startE  = 1'b1;
        dif.signedE = 1'b0;
        dif.srcaE   = 32'd9;
        dif.srcbE   = 32'd3;
        we1 = -1;
        we2 = -1;
        nwe = 0;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (k == 1) dif.startE = 1'b0;
            if (k == W + 1) begin
                dif.startE = 1'b1;
                dif.srcaE  = 32'd10;
                dif.srcbE  = 32'd4;
            end
            if (k == W + 3) dif.startE = 1'b0;
            #1;
            if (k == W + 1) chk("b2b_done_stall", dif.stall_div, 0);
            if (k == W + 2) chk("b2b_restart_stall", dif.stall_div, 1);
            if (dif.hilo_we) begin
                nwe++;
                if (we1 < 0) begin
                    we1 = k;
                    chk("b2b_first_lo", dif.lo_o, 3);
                    chk("b2b_first_hi", dif.hi_o, 0);
                end else if (we2 < 0) begin
                    we2 = k;
                    chk("b2b_second_lo", dif.lo_o, 2);
                    chk("b2b_second_hi", dif.hi_o, 2);
                end
            end
        end
        chk("b2b_strobes", nwe, 2);
        chk("b2b_first_cycle", we1, W + 1);
        chk("b2b_interval", we2 - we1, W + 2);

        // Asynchronous reset in the middle of BUSY.
        @(negedge clk);
        dif.startE = 1'b1;
        dif.srcaE  = 32'd100;
        dif.srcbE  = 32'd7;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            dif.startE = 1'b0;
        end
        #1 resetn = 1'b0;
        #1;
        chk("midrst_stall", dif.stall_div, 0);
        chk("midrst_busy", dif.busy, 0);
        chk("midrst_we", dif.hilo_we, 0);
        chk("midrst_hi", dif.hi_o, 0);
        chk("midrst_lo", dif.lo_o, 0);
        @(negedge clk);
        resetn = 1'b1;
        model(32'd5000, 32'd7, 1'b0, elo, ehi);
        check_div("post_reset", 32'd5000, 32'd7, 1'b0, elo, ehi);

        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            rs = 1'($urandom);
            model(ra, rb, rs, elo, ehi);
            check_div($sformatf("rand%0d", i), ra, rb, rs, elo, ehi);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/div_stall_unit.md
# div_stall_unit

Iterative 32-bit divider for MIPS DIV/DIVU in the execute stage. It raises a stall request to the hazard unit, so that unit is the receiver and this block the initiator of the stall interface. While the divide runs, the request holds F/D/E and bubbles M. On completion it drops the request for one cycle and issues a single HI/LO write pulse.

## Interface
Parameters:
- WIDTH, 32, operand/result width; counter is $clog2(WIDTH)+1 bits.

Ports:
- clk  in  1  pipeline clock.
- resetn  in  1  reset, asynchronous and active-low.
- startE  in  1  execute-stage instruction is DIV/DIVU.
- signedE  in  1  1 = DIV (signed), 0 = DIVU.
- srcaE  in  WIDTH  dividend (post-forwarding rs value).
- srcbE  in  WIDTH  divisor (post-forwarding rt value).
- cancel  in  1  exception/ERET flush of execute stage; aborts the operation.
- stall_div  out  1  stall request to the hazard unit, ORed into stallF/stallD/flush-of-M.
- busy  out  1  state is BUSY.
- hilo_we  out  1  one-cycle HI/LO write strobe.
- hi_o  out  WIDTH  remainder.
- lo_o  out  WIDTH  quotient.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE:
  - On startE & ~cancel: latch |srcaE| and |srcbE| (absolute value only when signedE), the quotient sign (sa^sb) and remainder sign (sa), and clear the remainder. Count = WIDTH. Go to BUSY.
  - stall_div = startE & ~cancel, combinational in the same cycle.
- BUSY:
  - Each cycle runs one restoring step: shift {rem,quo} left 1, trial-subtract the divisor, set the quotient LSB on no-borrow, decrement count.
  - When count reaches 1, the step's result is sign-corrected (negate quotient if qsign, negate remainder if rsign) and registered into hi_o/lo_o. Go to DONE.
  - stall_div = 1.
- DONE:
  - hilo_we = ~cancel, stall_div = 0, so the instruction advances to M at the end of this cycle.
  - Always go to IDLE; startE is ignored in DONE, so the same instruction never restarts.
- cancel:
  - In BUSY, cancel returns to IDLE next cycle. hilo_we stays 0 and hi_o/lo_o keep their prior values.
  - In DONE, cancel suppresses hilo_we.
- Arithmetic:
  - Trial subtract is WIDTH+1 bits. Absolute value of 0x80000000 is 0x80000000 unsigned.
  - Signed 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- Divide by zero without the macro: the natural iteration result, lo=all ones and hi=|dividend|, with signed correction applied.
- hi_o/lo_o hold their values until the next completion.

## Timing
- Reset values: state IDLE, count 0, stall_div 0, busy 0, hilo_we 0, hi_o 0, lo_o 0.
- Normal latency, with start sampled in IDLE at cycle t:
  - BUSY occupies t+1..t+WIDTH.
  - DONE is at t+WIDTH+1, with hilo_we=1 and results valid.
  - stall_div is high for cycles t..t+WIDTH (WIDTH+1 cycles).
- Back-to-back divides: the second DIV enters E in the cycle after DONE and starts from IDLE. The minimum issue interval is WIDTH+2 cycles.
- Reset mid-operation: asynchronous return to all reset values; no write strobe.
- Operands are sampled only at start. Changes on srcaE/srcbE during BUSY are ignored.

## Configuration
- DIV_ZERO_EARLY_EN:
  - Defined: in IDLE, if startE and srcbE==0, go directly to DONE with lo_o=all ones and hi_o=srcaE unmodified, regardless of signedE. stall_div is high for exactly cycle t; hilo_we is at t+1.
  - Undefined: divide-by-zero takes the full WIDTH+1-cycle path with the iterative result.

## Test plan
- DIVU 100/7 -> stall_div high 33 cycles, then hilo_we for 1 cycle with lo_o=14, hi_o=2.
- DIV 0xFFFFFFF9 (-7) / 2 -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF; also 0x80000000/0xFFFFFFFF -> lo_o=0x80000000, hi_o=0.
- cancel asserted at BUSY cycle 10 -> IDLE next cycle, stall_div low, no hilo_we, hi_o/lo_o unchanged from the previous result.
- Two consecutive DIVU (9/3, then 10/4) -> strobes 34 cycles apart: lo_o=3/hi_o=0, then lo_o=2/hi_o=2.
- resetn pulled low at BUSY cycle 5 -> all outputs 0 immediately; a new start after release computes correctly.
- DIVU 5/0 -> lo_o=0xFFFFFFFF, hi_o=5; hilo_we at cycle t+1 with DIV_ZERO_EARLY_EN defined, at cycle t+33 without it.
